// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Hazard detector for the ID stage. It decides whether the instruction in ID
// can proceed. If that instruction needs a result that cannot yet be forwarded,
// the unit freezes the PC and IF/ID and raises stall_o. stall_o drives the
// bubble mux that zeroes the ID/EX control word.
//
// A branch in ID that depends on a load in EX needs two bubbles. The first
// bubble is signalled combinationally in RUN. The second comes from the HOLD
// state, which holds stall_o high whatever the EX/MEM inputs do.
//
// A taken branch flushes IF/ID unless a stall is active. In that case the
// branch is resolved again once the stall has cleared.
//
// A saturating counter accumulates the number of stall cycles.
//
// Ports
//   clk_i            pipeline clock, rising edge
//   rst_i            asynchronous, active-high reset
//   id_rs_i/id_rt_i  source registers of the ID instruction
//   id_uses_rs_i     ID instruction reads rs
//   id_uses_rt_i     ID instruction reads rt
//   id_is_branch_i   ID instruction is a branch/jr resolved in ID
//   branch_taken_i   ID branch resolved taken this cycle
//   ex_reg_write_i   ID/EX instruction writes a register
//   ex_mem_read_i    ID/EX instruction is a load when non-zero
//   ex_write_reg_i   ID/EX destination register
//   mem_mem_read_i   EX/MEM instruction is a load when non-zero
//   mem_write_reg_i  EX/MEM destination register
//   clear_cnt_i      synchronous clear of the stall counter
//   stall_o          1 = bubble mux zeroes the control word
//   pc_write_o       0 = hold PC
//   ifid_write_o     0 = hold IF/ID
//   ifid_flush_o     1 = zero IF/ID on the next edge
//   stall_cnt_o      saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic             id_is_branch_i,
    input  logic             branch_taken_i,
    input  logic             ex_reg_write_i,
    input  logic [1:0]       ex_mem_read_i,
    input  logic [REG_W-1:0] ex_write_reg_i,
    input  logic [1:0]       mem_mem_read_i,
    input  logic [REG_W-1:0] mem_write_reg_i,
    input  logic             clear_cnt_i,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic       dep_e;
    logic       dep_m;
    logic       ex_load;
    logic       mem_load;
    logic [1:0] need;
    logic       stall_raw;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    always_comb begin
        dep_e = (ex_write_reg_i != '0) &&
                ((id_uses_rs_i && (id_rs_i == ex_write_reg_i)) ||
                 (id_uses_rt_i && (id_rt_i == ex_write_reg_i)));
        dep_m = (mem_write_reg_i != '0) &&
                ((id_uses_rs_i && (id_rs_i == mem_write_reg_i)) ||
                 (id_uses_rt_i && (id_rt_i == mem_write_reg_i)));
        ex_load  = (ex_mem_read_i != 2'b00);
        mem_load = (mem_mem_read_i != 2'b00);
    end

    // Number of bubbles needed. The first matching case wins.
    // Branches compare operands in ID, so they wait longer than ALU consumers.
    always_comb begin
        need = 2'd0;
        if (id_is_branch_i && dep_e && ex_load)
            need = 2'd2;
        else if (id_is_branch_i && dep_e && ex_reg_write_i)
            need = 2'd1;
        else if (id_is_branch_i && dep_m && mem_load)
            need = 2'd1;
        else if (!id_is_branch_i && dep_e && ex_load)
            need = 2'd1;
    end

    // HOLD stalls unconditionally. Its EX/MEM view is stale by then.
    assign stall_raw = (state_q == HOLD) || (need != 2'd0);

    // Reset forces the outputs to the free-running values at once,
    // independent of whatever the ID/EX inputs happen to show.
    assign stall_o      = stall_raw && !rst_i;
    assign pc_write_o   = !stall_o;
    assign ifid_write_o = !stall_o;
    assign ifid_flush_o = branch_taken_i && !stall_o;
    assign stall_cnt_o  = cnt_q;

    // Clear has priority over increment. The increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_cnt_i)
            cnt_d = '0;
        else if (stall_raw && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                RUN: begin
                    if (need == 2'd2) begin
                        state_q <= HOLD;
                        rem_q   <= 2'd1;
                    end
                end
                HOLD: begin
                    // The "<= 1" test also covers rem_q == 0, so HOLD always exits.
                    if (rem_q <= 2'd1) begin
                        state_q <= RUN;
                        rem_q   <= 2'd0;
                    end else begin
                        rem_q <= rem_q - 2'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    rem_q   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs_i, id_rt_i;
    logic       id_uses_rs_i, id_uses_rt_i, id_is_branch_i, branch_taken_i;
    logic       ex_reg_write_i;
    logic [1:0] ex_mem_read_i, mem_mem_read_i;
    logic [4:0] ex_write_reg_i, mem_write_reg_i;
    logic       clear_cnt_i;

    logic        stall_o, pc_write_o, ifid_write_o, ifid_flush_o;
    logic [15:0] stall_cnt_o;
    logic        stall4, pcw4, ifw4, flush4;
    logic [3:0]  cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    hazard_stall_unit #(.REG_W(5), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
        .id_is_branch_i(id_is_branch_i), .branch_taken_i(branch_taken_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_write_reg_i(ex_write_reg_i), .mem_mem_read_i(mem_mem_read_i),
        .mem_write_reg_i(mem_write_reg_i), .clear_cnt_i(clear_cnt_i),
        .stall_o(stall_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .ifid_flush_o(ifid_flush_o), .stall_cnt_o(stall_cnt_o)
    );

    hazard_stall_unit #(.REG_W(5), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
        .id_is_branch_i(id_is_branch_i), .branch_taken_i(branch_taken_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_write_reg_i(ex_write_reg_i), .mem_mem_read_i(mem_mem_read_i),
        .mem_write_reg_i(mem_write_reg_i), .clear_cnt_i(clear_cnt_i),
        .stall_o(stall4), .pc_write_o(pcw4), .ifid_write_o(ifw4),
        .ifid_flush_o(flush4), .stall_cnt_o(cnt4)
    );

    task automatic idle_inputs();
        id_rs_i = 0; id_rt_i = 0; id_uses_rs_i = 0; id_uses_rt_i = 0;
        id_is_branch_i = 0; branch_taken_i = 0;
        ex_reg_write_i = 0; ex_mem_read_i = 0; ex_write_reg_i = 0;
        mem_mem_read_i = 0; mem_write_reg_i = 0; clear_cnt_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Zero both counters with idle inputs, leaving time at posedge+1.
    task automatic clear_counters();
        idle_inputs();
        clear_cnt_i = 1;
        step();
        clear_cnt_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        idle_inputs();
        #2;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_o); end
        total++; if (pc_write_o !== 1'b1 || ifid_write_o !== 1'b1) begin bad++; $display("FAIL reset_write got=%b%b want=11", pc_write_o, ifid_write_o); end
        total++; if (ifid_flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", ifid_flush_o); end
        total++; if (stall_cnt_o !== 16'd0 || cnt4 !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt_o, cnt4); end
        @(negedge clk_i);
        rst_i = 0;
        step();
        $display("reset: stall=%b pcw=%b cnt=%0d", stall_o, pc_write_o, stall_cnt_o);
    endtask

    task automatic test_load_use();
        clear_counters();
        ex_reg_write_i = 1; ex_mem_read_i = 2'b01; ex_write_reg_i = 8;
        id_rs_i = 8; id_uses_rs_i = 1;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", stall_o); end
        total++; if (pc_write_o !== 1'b0 || ifid_write_o !== 1'b0) begin bad++; $display("FAIL lu_write got=%b%b want=00", pc_write_o, ifid_write_o); end
        step();
        ex_reg_write_i = 0; ex_mem_read_i = 0; ex_write_reg_i = 0;
        #1;
        total++; if (stall_o !== 1'b0 || pc_write_o !== 1'b1) begin bad++; $display("FAIL lu_bubble got stall=%b pcw=%b want 0,1", stall_o, pc_write_o); end
        step();
        total++; if (stall_cnt_o !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt_o); end
        $display("load_use: cnt=%0d", stall_cnt_o);
    endtask

    task automatic test_branch_load();
        clear_counters();
        ex_reg_write_i = 1; ex_mem_read_i = 2'b01; ex_write_reg_i = 8;
        id_is_branch_i = 1; id_rt_i = 8; id_uses_rt_i = 1;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL bl_stall1 got=%b want=1", stall_o); end
        step();
        ex_reg_write_i = 0; ex_mem_read_i = 0; ex_write_reg_i = 0;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL bl_stall2 got=%b want=1", stall_o); end
        step();
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL bl_release got=%b want=0", stall_o); end
        idle_inputs();
        step();
        total++; if (stall_cnt_o !== 16'd2) begin bad++; $display("FAIL bl_cnt got=%0d want=2", stall_cnt_o); end
        $display("branch_load: cnt=%0d", stall_cnt_o);
    endtask

    task automatic test_branch_other();
        idle_inputs();
        // Branch after an ALU producer in EX: one bubble, no HOLD.
        ex_reg_write_i = 1; ex_write_reg_i = 5; id_is_branch_i = 1; id_rs_i = 5; id_uses_rs_i = 1;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL br_alu got=%b want=1", stall_o); end
        step();
        ex_reg_write_i = 0; ex_write_reg_i = 0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL br_alu_once got=%b want=0", stall_o); end
        // A load in MEM blocks a branch but not an ALU consumer.
        mem_mem_read_i = 2'b10; mem_write_reg_i = 9; id_rs_i = 9;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL br_mem got=%b want=1", stall_o); end
        id_is_branch_i = 0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL alu_mem got=%b want=0", stall_o); end
        // An ALU consumer after an ALU producer is forwarded.
        idle_inputs();
        ex_reg_write_i = 1; ex_write_reg_i = 6; id_rt_i = 6; id_uses_rt_i = 1;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL alu_alu got=%b want=0", stall_o); end
        idle_inputs();
        step();
        $display("branch_other: stall=%b", stall_o);
    endtask

    task automatic test_reg_zero();
        idle_inputs();
        ex_reg_write_i = 1; ex_mem_read_i = 2'b01; ex_write_reg_i = 0; id_rs_i = 0; id_uses_rs_i = 1;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL r0 got=%b want=0", stall_o); end
        ex_write_reg_i = 8; id_rs_i = 8; id_uses_rs_i = 0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL unused_rs got=%b want=0", stall_o); end
        idle_inputs();
        step();
        $display("reg_zero: stall=%b", stall_o);
    endtask

    task automatic test_flush();
        idle_inputs();
        branch_taken_i = 1;
        #1;
        total++; if (ifid_flush_o !== 1'b1 || pc_write_o !== 1'b1) begin bad++; $display("FAIL flush got flush=%b pcw=%b want 1,1", ifid_flush_o, pc_write_o); end
        ex_reg_write_i = 1; ex_mem_read_i = 2'b01; ex_write_reg_i = 3; id_rs_i = 3; id_uses_rs_i = 1;
        #1;
        total++; if (ifid_flush_o !== 1'b0 || stall_o !== 1'b1) begin bad++; $display("FAIL flush_stall got flush=%b stall=%b want 0,1", ifid_flush_o, stall_o); end
        idle_inputs();
        step();
        $display("flush: flush=%b", ifid_flush_o);
    endtask

    task automatic test_reset_mid_hold();
        clear_counters();
        ex_reg_write_i = 1; ex_mem_read_i = 2'b01; ex_write_reg_i = 8;
        id_is_branch_i = 1; id_rt_i = 8; id_uses_rt_i = 1;
        step();
        idle_inputs();
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL hold_before_rst got=%b want=1", stall_o); end
        #1 rst_i = 1;
        #1;
        total++; if (stall_o !== 1'b0 || pc_write_o !== 1'b1 || ifid_flush_o !== 1'b0) begin bad++; $display("FAIL rst_async got stall=%b pcw=%b flush=%b want 0,1,0", stall_o, pc_write_o, ifid_flush_o); end
        total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", stall_cnt_o); end
        #1 rst_i = 0;
        step();
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL after_rst_run got=%b want=0", stall_o); end
        $display("reset_mid_hold: stall=%b cnt=%0d", stall_o, stall_cnt_o);
    endtask

    task automatic test_saturate();
        clear_counters();
        ex_reg_write_i = 1; ex_mem_read_i = 2'b11; ex_write_reg_i = 12; id_rt_i = 12; id_uses_rt_i = 1;
        for (int i = 0; i < 20; i++) step();
        total++; if (cnt4 !== 4'd15) begin bad++; $display("FAIL sat4 got=%0d want=15", cnt4); end
        total++; if (stall_cnt_o !== 16'd20) begin bad++; $display("FAIL cnt16 got=%0d want=20", stall_cnt_o); end
        clear_cnt_i = 1;
        step();
        total++; if (cnt4 !== 4'd0 || stall_cnt_o !== 16'd0) begin bad++; $display("FAIL clr_prio got=%0d/%0d want=0/0", cnt4, stall_cnt_o); end
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL clr_stall got=%b want=1", stall_o); end
        idle_inputs();
        step();
        $display("saturate: cnt4=%0d cnt16=%0d", cnt4, stall_cnt_o);
    endtask

    task automatic test_back_to_back();
        clear_counters();
        ex_reg_write_i = 1; ex_mem_read_i = 2'b01; ex_write_reg_i = 3; id_rs_i = 3; id_uses_rs_i = 1;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b want=1", stall_o); end
        step();
        ex_write_reg_i = 4; id_rs_i = 0; id_uses_rs_i = 0; id_rt_i = 4; id_uses_rt_i = 1;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b want=1", stall_o); end
        step();
        idle_inputs();
        step();
        total++; if (stall_cnt_o !== 16'd2) begin bad++; $display("FAIL b2b_cnt got=%0d want=2", stall_cnt_o); end
        $display("back_to_back: cnt=%0d", stall_cnt_o);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_other();
        test_reg_zero();
        test_flush();
        test_reset_mid_hold();
        test_saturate();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
